enemy_formation_ctrl: RTL and testbench
=======================================

Name: enemy_formation_ctrl

Overview:
Frame-rate controller that drives the shared enemy movement interface consumed by every enemy sprite renderer. It generates enemy_direction_X, enemy_direction_Y, delete_enemies and is_playing. It keeps a shadow copy of the formation bounding box and tracks kills, then decides march, drop, wave-cleared and invasion events. It sits between the game top-level and the array of enemy renderers, one instance per wave.

Parameters:
NUM_ENEMIES, 8, number of enemies in the formation (1..16)
INIT_X, 10'd40, formation left edge at wave start (px)
INIT_Y, 10'd40, formation top edge at wave start (px)
FORM_W, 10'd400, formation bounding-box width (px)
FORM_H, 10'd150, formation bounding-box height (px)
SCREEN_L, 10'd0, leftmost legal left-edge x
SCREEN_R, 10'd639, rightmost legal right-edge x
DROP_ROWS, 10'd10, frames spent moving down per edge hit
BOTTOM_Y, 10'd430, formation bottom edge at which invasion occurs

Ports:
frame_clk  in  1  frame-rate clock, one edge per video frame
Reset  in  1  reset, synchronous, active-high
start  in  1  begin wave; level, sampled each frame
kill_mask  in  NUM_ENEMIES  sticky per-enemy dead flags; bit i=1 means enemy i is destroyed
is_playing  out  1  formation active (MARCH_R/MARCH_L/DROP)
enemy_direction_X  out  1  0=left, 1=right
enemy_direction_Y  out  1  0=stay, 1=move down
delete_enemies  out  1  one-frame pulse that removes all enemy sprites
formation_x  out  10  shadow left edge, equals renderer start_x
formation_y  out  10  shadow top edge
alive_count  out  5  NUM_ENEMIES minus popcount(kill_mask), registered
wave_cleared  out  1  one-frame pulse when alive_count reaches 0
game_over  out  1  sticky; set on invasion, cleared only by Reset

Behaviour:
- All outputs are registered and update on the posedge of frame_clk. Reset has priority over every other event.
- Reset values:
  - state=IDLE; formation_x=INIT_X; formation_y=INIT_Y.
  - enemy_direction_X=1; enemy_direction_Y=0.
  - is_playing=0; delete_enemies=0; wave_cleared=0; game_over=0.
  - alive_count=NUM_ENEMIES; drop counter=0.
- Shadow tracking: while is_playing=1, formation_x and formation_y are updated on each edge using the direction outputs currently on the wire, exactly as a renderer does.
  - X: +1 if dir_X=1, -1 if dir_X=0. X stays unchanged when dir_Y=1.
  - Y: +1 if dir_Y=1.
- Boundary decisions use next-position values (nx, ny). New direction outputs therefore take effect from the following edge, and the box never exceeds the screen bounds.
- FSM states and transitions:
  - IDLE: start=1 and game_over=0 -> MARCH_R, is_playing<=1. Otherwise stay in IDLE.
  - MARCH_R: dir_X=1, dir_Y=0. If nx+FORM_W-1 == SCREEN_R -> DROP; load drop counter=DROP_ROWS, set resume=LEFT.
  - MARCH_L: dir_X=0, dir_Y=0. If nx == SCREEN_L -> DROP; resume=RIGHT.
  - DROP: dir_Y=1 and dir_X held. Counter decrements each frame. At 1 -> resume state, with dir_X set to the new side and dir_Y cleared.
  - CLEARED: is_playing=0. start=1 -> reload INIT_X/INIT_Y -> MARCH_R.
  - INVADED: is_playing=0; game_over=1. Terminal until Reset.
- Kill handling:
  - alive_count is recomputed every frame from kill_mask.
  - If the registered alive_count transitions to 0 from any active state -> CLEARED. wave_cleared and delete_enemies pulse high for exactly one frame.
- Invasion: in any active state, if ny+FORM_H-1 >= BOTTOM_Y -> INVADED. delete_enemies pulses for one frame.
- Priority for simultaneous events: Reset > invasion > cleared > edge/drop.
  - An edge hit and a kill-out on the same frame resolve to CLEARED.
  - A drop reaching BOTTOM_Y resolves to INVADED.
- kill_mask bits that fall back to 0 are ignored. A kill is permanent within a wave; alive_count never increases until a new wave starts (CLEARED->MARCH_R).
- Reset asserted mid-DROP or mid-pulse clears all state on that edge; delete_enemies is not emitted.

Optional Feature:
Macro WAVE_AUTORESTART_EN.
- Defined: CLEARED starts a 120-frame countdown. At expiry the block reloads INIT_X/INIT_Y, clears the kill history and enters MARCH_R without start. A 1-bit output wave_restart pulses for one frame on that transition.
- Undefined: CLEARED waits for start, and the wave_restart port does not exist.

Test Plan:
- Reset, then start=1 -> next edge: is_playing=1, dir_X=1. formation_x increments 1 per frame from 40.
- Right edge (defaults): formation_x reaches 240 (240+400-1=639) -> DROP. dir_Y=1 for exactly 10 frames, formation_y 40->50, then dir_X=0, dir_Y=0, formation_x decrements.
- Left edge: formation_x reaches 0 -> DROP for 10 frames -> MARCH_R. formation_x never wraps below 0.
- kill_mask bits set one per frame to 8'hFF -> alive_count 8..0. On the frame alive_count hits 0: one-frame wave_cleared=1 and delete_enemies=1, is_playing=0.
- Marching continues until formation_y+149 >= 430 (formation_y=281) -> game_over=1 sticky and delete_enemies one-frame pulse. A later start=1 has no effect.
- Reset=1 during DROP frame 5 -> next edge shows all reset values. A following start restarts at formation_x=40, formation_y=40.

Source files
------------

// File: rtl/enemy_formation_ctrl_if.sv
// Shared enemy movement bus between the formation controller and the sprite renderers.
// Carries wave_restart only when WAVE_AUTORESTART_EN is defined.
interface enemy_formation_ctrl_if #(
  parameter int unsigned NUM_ENEMIES = 8
) ();
  logic                   start;
  logic [NUM_ENEMIES-1:0] kill_mask;
  logic                   is_playing;
  logic                   enemy_direction_X;
  logic                   enemy_direction_Y;
  logic                   delete_enemies;
  logic [9:0]             formation_x;
  logic [9:0]             formation_y;
  logic [4:0]             alive_count;
  logic                   wave_cleared;
  logic                   game_over;
`ifdef WAVE_AUTORESTART_EN
  logic                   wave_restart;

  modport master (
    input  start, kill_mask,
    output is_playing, enemy_direction_X, enemy_direction_Y, delete_enemies,
           formation_x, formation_y, alive_count, wave_cleared, game_over, wave_restart
  );
  modport slave (
    output start, kill_mask,
    input  is_playing, enemy_direction_X, enemy_direction_Y, delete_enemies,
           formation_x, formation_y, alive_count, wave_cleared, game_over, wave_restart
  );
`else
  modport master (
    input  start, kill_mask,
    output is_playing, enemy_direction_X, enemy_direction_Y, delete_enemies,
           formation_x, formation_y, alive_count, wave_cleared, game_over
  );
  modport slave (
    output start, kill_mask,
    input  is_playing, enemy_direction_X, enemy_direction_Y, delete_enemies,
           formation_x, formation_y, alive_count, wave_cleared, game_over
  );
`endif
endinterface

// File: rtl/enemy_formation_ctrl.sv
// Frame-rate enemy formation controller: march/drop/cleared/invaded decisions from a shadow
// bounding box and sticky kill history. WAVE_AUTORESTART_EN enables timed wave restart.
module enemy_formation_ctrl #(
  parameter int unsigned NUM_ENEMIES = 8,
  parameter logic [9:0]  INIT_X      = 10'd40,
  parameter logic [9:0]  INIT_Y      = 10'd40,
  parameter logic [9:0]  FORM_W      = 10'd400,
  parameter logic [9:0]  FORM_H      = 10'd150,
  parameter logic [9:0]  SCREEN_L    = 10'd0,
  parameter logic [9:0]  SCREEN_R    = 10'd639,
  parameter logic [9:0]  DROP_ROWS   = 10'd10,
  parameter logic [9:0]  BOTTOM_Y    = 10'd430
) (
  input logic                   frame_clk,
  input logic                   Reset,
  enemy_formation_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StMarchR, StMarchL, StDrop, StCleared, StInvaded
  } state_e;

  state_e                 state_q, state_d;
  logic [9:0]             x_q, x_d, y_q, y_d;
  logic                   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic                   playing_q, playing_d;
  logic                   del_q, del_d, clr_q, clr_d, over_q, over_d;
  logic [4:0]             alive_q, alive_d;
  logic [9:0]             cnt_q, cnt_d;
  logic                   resume_q, resume_d;  // 1: resume marching right after the drop
  logic [NUM_ENEMIES-1:0] hist_q, hist_d;
`ifdef WAVE_AUTORESTART_EN
  logic                   restart_q, restart_d;
`endif

  logic [9:0] nx, ny;
  logic [4:0] kills;
  logic       right_hit, left_hit, bottom_hit, active, relaunch;

  always_comb begin
    state_d   = state_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    playing_d = playing_q;
    over_d    = over_q;
    cnt_d     = cnt_q;
    resume_d  = resume_q;
    del_d     = 1'b0;
    clr_d     = 1'b0;
    relaunch  = 1'b0;
`ifdef WAVE_AUTORESTART_EN
    restart_d = 1'b0;
`endif

    // Mirror the renderer: move with the direction currently on the bus.
    nx = x_q;
    ny = y_q;
    if (playing_q) begin
      if (dir_y_q) begin
        ny = y_q + 10'd1;
      end else if (dir_x_q) begin
        nx = x_q + 10'd1;
      end else begin
        nx = x_q - 10'd1;
      end
    end
    x_d = nx;
    y_d = ny;

    hist_d = hist_q | bus.kill_mask;
    kills  = '0;
    for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
      kills = kills + 5'(hist_d[i]);
    end
    alive_d = 5'(NUM_ENEMIES) - kills;

    right_hit  = ({1'b0, nx} + {1'b0, FORM_W} - 11'd1) == {1'b0, SCREEN_R};
    left_hit   = nx == SCREEN_L;
    bottom_hit = ({1'b0, ny} + {1'b0, FORM_H} - 11'd1) >= {1'b0, BOTTOM_Y};
    active     = (state_q == StMarchR) || (state_q == StMarchL) || (state_q == StDrop);

    unique case (state_q)
      StIdle: begin
        if (bus.start && !over_q) begin
          state_d   = StMarchR;
          playing_d = 1'b1;
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b0;
        end
      end
      StMarchR: begin
        if (right_hit) begin
          state_d  = StDrop;
          cnt_d    = DROP_ROWS;
          resume_d = 1'b0;
          dir_y_d  = 1'b1;
        end
      end
      StMarchL: begin
        if (left_hit) begin
          state_d  = StDrop;
          cnt_d    = DROP_ROWS;
          resume_d = 1'b1;
          dir_y_d  = 1'b1;
        end
      end
      StDrop: begin
        cnt_d = cnt_q - 10'd1;
        if (cnt_q <= 10'd1) begin
          state_d = resume_q ? StMarchR : StMarchL;
          dir_x_d = resume_q;
          dir_y_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StCleared: begin
`ifdef WAVE_AUTORESTART_EN
        cnt_d = cnt_q - 10'd1;
        if (cnt_q <= 10'd1) begin
          relaunch  = 1'b1;
          restart_d = 1'b1;
          cnt_d     = '0;
        end
`else
        relaunch = bus.start;
`endif
      end
      StInvaded: begin
      end
      default: state_d = StIdle;
    endcase

    if (relaunch) begin
      state_d   = StMarchR;
      x_d       = INIT_X;
      y_d       = INIT_Y;
      hist_d    = '0;
      alive_d   = 5'(NUM_ENEMIES);
      playing_d = 1'b1;
      dir_x_d   = 1'b1;
      dir_y_d   = 1'b0;
    end

    // Invasion outranks a kill-out, which outranks any edge or drop decision.
    if (active) begin
      if (bottom_hit) begin
        state_d   = StInvaded;
        playing_d = 1'b0;
        over_d    = 1'b1;
        del_d     = 1'b1;
        dir_y_d   = 1'b0;
        cnt_d     = '0;
      end else if (alive_d == 5'd0) begin
        state_d   = StCleared;
        playing_d = 1'b0;
        del_d     = 1'b1;
        clr_d     = 1'b1;
        dir_y_d   = 1'b0;
`ifdef WAVE_AUTORESTART_EN
        cnt_d     = 10'd120;
`else
        cnt_d     = '0;
`endif
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      x_q       <= INIT_X;
      y_q       <= INIT_Y;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b0;
      playing_q <= 1'b0;
      del_q     <= 1'b0;
      clr_q     <= 1'b0;
      over_q    <= 1'b0;
      alive_q   <= 5'(NUM_ENEMIES);
      cnt_q     <= '0;
      resume_q  <= 1'b0;
      hist_q    <= '0;
`ifdef WAVE_AUTORESTART_EN
      restart_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      playing_q <= playing_d;
      del_q     <= del_d;
      clr_q     <= clr_d;
      over_q    <= over_d;
      alive_q   <= alive_d;
      cnt_q     <= cnt_d;
      resume_q  <= resume_d;
      hist_q    <= hist_d;
`ifdef WAVE_AUTORESTART_EN
      restart_q <= restart_d;
`endif
    end
  end

  assign bus.is_playing        = playing_q;
  assign bus.enemy_direction_X = dir_x_q;
  assign bus.enemy_direction_Y = dir_y_q;
  assign bus.delete_enemies    = del_q;
  assign bus.formation_x       = x_q;
  assign bus.formation_y       = y_q;
  assign bus.alive_count       = alive_q;
  assign bus.wave_cleared      = clr_q;
  assign bus.game_over         = over_q;
`ifdef WAVE_AUTORESTART_EN
  assign bus.wave_restart      = restart_q;
`endif

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Self-checking bench for enemy_formation_ctrl: vector table, directed edge/invasion/reset
// sequences, then randomized frames against a frame-level behavioural model.
module tb_enemy_formation_ctrl;

  logic frame_clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  enemy_formation_ctrl_if #(.NUM_ENEMIES(8)) bus ();

  enemy_formation_ctrl #(.NUM_ENEMIES(8)) u_dut (
    .frame_clk (frame_clk),
    .Reset     (rst),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame-level model: a mode, the frames left in a drop, and plain integer positions.
  localparam int MIdle = 0, MMarch = 1, MDrop = 2, MCleared = 3, MInvaded = 4;
  int         mode, left, mx, my, malive;
  logic       mdx, mdy, mplay, mdel, mclr, mover;
  logic [7:0] dead;

  task automatic model_step(input logic r, input logic s, input logic [7:0] k);
    logic was_active;
    if (r) begin
      mode = MIdle; left = 0; mx = 40; my = 40; malive = 8; dead = '0;
      mdx = 1'b1; mdy = 1'b0; mplay = 1'b0; mdel = 1'b0; mclr = 1'b0; mover = 1'b0;
      return;
    end
    was_active = mplay;
    mdel = 1'b0;
    mclr = 1'b0;
    if (mplay) begin
      if (mdy) my++;
      else if (mdx) mx++;
      else mx--;
    end
    dead   = dead | k;
    malive = 8 - $countones(dead);
    case (mode)
      MIdle: if (s && !mover) begin mode = MMarch; mplay = 1'b1; mdx = 1'b1; mdy = 1'b0; end
      MMarch: begin
        if ((mdx && mx + 400 - 1 == 639) || (!mdx && mx == 0)) begin
          mode = MDrop; left = 10; mdy = 1'b1;
        end
      end
      MDrop: begin
        left--;
        if (left == 0) begin mode = MMarch; mdx = !mdx; mdy = 1'b0; end
      end
      MCleared: begin
        if (s) begin
          mx = 40; my = 40; dead = '0; malive = 8;
          mode = MMarch; mplay = 1'b1; mdx = 1'b1; mdy = 1'b0;
        end
      end
      default: ;
    endcase
    if (was_active) begin
      if (my + 150 - 1 >= 430) begin
        mode = MInvaded; mplay = 1'b0; mover = 1'b1; mdel = 1'b1; mdy = 1'b0;
      end else if (malive == 0) begin
        mode = MCleared; mplay = 1'b0; mdel = 1'b1; mclr = 1'b1; mdy = 1'b0;
      end
    end
  endtask

  function automatic logic [30:0] pk(logic p, logic dx, logic dy, logic del, logic clr,
                                     logic ov, logic [9:0] x, logic [9:0] y, logic [4:0] a);
    return {p, dx, dy, del, clr, ov, x, y, a};
  endfunction

  function automatic logic [30:0] dut_vec();
    return pk(bus.is_playing, bus.enemy_direction_X, bus.enemy_direction_Y, bus.delete_enemies,
              bus.wave_cleared, bus.game_over, bus.formation_x, bus.formation_y,
              bus.alive_count);
  endfunction

  function automatic logic [30:0] model_vec();
    return pk(mplay, mdx, mdy, mdel, mclr, mover, 10'(mx), 10'(my), 5'(malive));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one edge, advance the model, sample 1ns later.
  task automatic tick(input logic r, input logic s, input logic [7:0] k);
    rst           = r;
    bus.start     = s;
    bus.kill_mask = k;
    @(posedge frame_clk);
    model_step(r, s, k);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [7:0] k;
    logic       p, dx, dy, del, clr;
    logic [9:0] x;
    logic [4:0] a;
  } vec_t;

  vec_t       vt[15];
  int         cnt;
  logic [7:0] kmask;
  logic       rr, ss;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.kill_mask = '0;
    vt[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 10'd40, 5'd8};
    vt[1]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 10'd40, 5'd8};
    vt[2]  = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 10'd40, 5'd8};
    vt[3]  = '{0, 0, 8'h01, 1, 1, 0, 0, 0, 10'd41, 5'd7};
    vt[4]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 10'd42, 5'd7};
    vt[5]  = '{0, 0, 8'h03, 1, 1, 0, 0, 0, 10'd43, 5'd6};
    vt[6]  = '{0, 0, 8'h07, 1, 1, 0, 0, 0, 10'd44, 5'd5};
    vt[7]  = '{0, 0, 8'h0F, 1, 1, 0, 0, 0, 10'd45, 5'd4};
    vt[8]  = '{0, 0, 8'h1F, 1, 1, 0, 0, 0, 10'd46, 5'd3};
    vt[9]  = '{0, 0, 8'h3F, 1, 1, 0, 0, 0, 10'd47, 5'd2};
    vt[10] = '{0, 0, 8'h7F, 1, 1, 0, 0, 0, 10'd48, 5'd1};
    vt[11] = '{0, 0, 8'hFF, 0, 1, 0, 1, 1, 10'd49, 5'd0};
    vt[12] = '{0, 0, 8'hFF, 0, 1, 0, 0, 0, 10'd49, 5'd0};
    vt[13] = '{0, 1, 8'h00, 1, 1, 0, 0, 0, 10'd40, 5'd8};
    vt[14] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 10'd41, 5'd8};

    #2;
    for (int i = 0; i < 15; i++) begin
      tick(vt[i].r, vt[i].s, vt[i].k);
      chk($sformatf("vec[%0d]", i), 32'(dut_vec()),
          32'(pk(vt[i].p, vt[i].dx, vt[i].dy, vt[i].del, vt[i].clr, 1'b0, vt[i].x, 10'd40,
                 vt[i].a)));
    end

    // Right edge, drop length, left edge.
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (199) tick(0, 0, 0);
    chk("pre_edge_x", bus.formation_x, 239);
    chk("pre_edge_dy", bus.enemy_direction_Y, 0);
    tick(0, 0, 0);
    chk("redge_x", bus.formation_x, 240);
    chk("redge_dy", bus.enemy_direction_Y, 1);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      if (bus.enemy_direction_Y) cnt++;
    end
    chk("rdrop_len", cnt, 10);
    chk("rdrop_y", bus.formation_y, 50);
    chk("rdrop_dx", bus.enemy_direction_X, 0);
    chk("rdrop_x", bus.formation_x, 240);
    tick(0, 0, 0);
    chk("march_l_x", bus.formation_x, 239);
    repeat (238) tick(0, 0, 0);
    chk("pre_ledge_x", bus.formation_x, 1);
    tick(0, 0, 0);
    chk("ledge_x", bus.formation_x, 0);
    chk("ledge_dy", bus.enemy_direction_Y, 1);
    repeat (10) tick(0, 0, 0);
    chk("ldrop_y", bus.formation_y, 60);
    chk("ldrop_dir", {bus.enemy_direction_X, bus.enemy_direction_Y}, 2'b10);
    chk("ldrop_x", bus.formation_x, 0);
    tick(0, 0, 0);
    chk("march_r_x", bus.formation_x, 1);

    // Keep marching until invasion.
    cnt = 0;
    while (!bus.game_over && cnt < 20000) begin
      tick(0, 0, 0);
      cnt++;
    end
    chk("invade_seen", bus.game_over, 1);
    chk("invade_y", bus.formation_y, 281);
    chk("invade_del", bus.delete_enemies, 1);
    chk("invade_play", bus.is_playing, 0);
    chk("invade_clr", bus.wave_cleared, 0);
    tick(0, 1, 0);
    chk("invade_del_pulse", bus.delete_enemies, 0);
    chk("invade_sticky", bus.game_over, 1);
    repeat (5) tick(0, 1, 0);
    chk("invade_nostart", {bus.is_playing, bus.game_over}, 2'b01);

    // Reset during the fifth drop frame.
    tick(1, 0, 0);
    chk("rst_over", bus.game_over, 0);
    tick(0, 1, 0);
    repeat (200) tick(0, 0, 0);
    chk("rst_seq_edge", {bus.enemy_direction_Y, 22'(bus.formation_x)}, {1'b1, 22'd240});
    repeat (5) tick(0, 0, 0);
    chk("rst_seq_drop_y", bus.formation_y, 45);
    tick(1, 1, 0);
    chk("rst_mid_drop", 32'(dut_vec()), 32'(pk(0, 1, 0, 0, 0, 0, 10'd40, 10'd40, 5'd8)));
    tick(0, 1, 0);
    chk("rst_restart", 32'(dut_vec()), 32'(pk(1, 1, 0, 0, 0, 0, 10'd40, 10'd40, 5'd8)));
    tick(0, 0, 0);
    chk("rst_restart_x", bus.formation_x, 41);

    // Randomized frames against the model.
    kmask = '0;
    tick(1, 0, 0);
    for (int f = 0; f < 30000; f++) begin
      if ($urandom_range(0, 149) == 0) kmask[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 99) == 0) kmask[$urandom_range(0, 7)] = 1'b0;
      if (mode == MCleared && $urandom_range(0, 9) == 0) kmask = '0;
      ss = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 4999) == 0);
      tick(rr, ss, kmask);
      chk($sformatf("rand[%0d]", f), 32'(dut_vec()), 32'(model_vec()));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
